// File: rtl/rtc_time_set_ctrl.sv
// rtc_time_set_ctrl: key-driven HH:MM:SS edit FSM between an RTC reader, a 6-digit display and an RTC writer.
// Optional build macro RTC_SET_TIMEOUT_EN adds an idle timeout that abandons an edit after TIMEOUT_CYCLES.
`default_nettype none

module rtc_time_set_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_mode,
  input  logic        key_up,
  input  logic        key_down,
  input  logic [23:0] rtc_bcd,
  input  logic        rtc_valid,
  output logic [23:0] seg_bcd,
  output logic [5:0]  seg_blink,
  output logic        wr_req,
  output logic [23:0] wr_bcd,
  input  logic        wr_ack
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SET_HOUR = 3'd1,
    SET_MIN  = 3'd2,
    SET_SEC  = 3'd3,
    WRITE    = 3'd4
  } state_t;

  state_t      state, state_nx;
  logic [23:0] live_q;
  logic [23:0] edit_q, edit_nx;
  logic        wr_req_q;
  logic [23:0] wr_bcd_q;

  logic        in_set;
  logic        up_only, dn_only;
  logic        adj;
  logic        tmo_hit;
  logic [7:0]  fld, fld_max, fld_adj;

  function automatic logic bcd_bad(input logic [7:0] v);
    return (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
  endfunction

  // Out-of-range or malformed fields wrap to 00 going up and to the maximum going down.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] mx);
    if (bcd_bad(v) || (v >= mx))
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] mx);
    if (bcd_bad(v) || (v > mx) || (v == 8'h00))
      return mx;
    else if (v[3:0] == 4'd0)
      return {v[7:4] - 4'd1, 4'd9};
    else
      return {v[7:4], v[3:0] - 4'd1};
  endfunction

  assign in_set  = (state == SET_HOUR) || (state == SET_MIN) || (state == SET_SEC);
  assign up_only = key_up & ~key_down;
  assign dn_only = key_down & ~key_up;
  assign adj     = in_set & ~key_mode & (up_only | dn_only);

`ifdef RTC_SET_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] tmo_cnt;
  logic             any_key;

  assign any_key = key_mode | key_up | key_down;
  assign tmo_hit = in_set && !any_key && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Held at zero outside SET states, so every entry into a SET state starts from zero.
  always_ff @(posedge clk) begin
    if (rst)
      tmo_cnt <= '0;
    else if (!in_set || any_key)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + CNT_W'(1);
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    edit_nx   = edit_q;
    fld       = 8'h00;
    fld_max   = 8'h00;
    seg_blink = 6'b000000;

    case (state)
      SET_HOUR: begin
        fld       = edit_q[23:16];
        fld_max   = 8'h23;
        seg_blink = 6'b000011;
      end
      SET_MIN: begin
        fld       = edit_q[15:8];
        fld_max   = 8'h59;
        seg_blink = 6'b001100;
      end
      SET_SEC: begin
        fld       = edit_q[7:0];
        fld_max   = 8'h59;
        seg_blink = 6'b110000;
      end
      default: ;
    endcase

    if (up_only)
      fld_adj = bcd_inc(fld, fld_max);
    else if (dn_only)
      fld_adj = bcd_dec(fld, fld_max);
    else
      fld_adj = fld;

    case (state)
      IDLE: begin
        if (key_mode) begin
          state_nx = SET_HOUR;
          edit_nx  = live_q;
        end
      end
      SET_HOUR: begin
        if (key_mode)
          state_nx = SET_MIN;
        else if (tmo_hit)
          state_nx = IDLE;
        else if (adj)
          edit_nx[23:16] = fld_adj;
      end
      SET_MIN: begin
        if (key_mode)
          state_nx = SET_SEC;
        else if (tmo_hit)
          state_nx = IDLE;
        else if (adj)
          edit_nx[15:8] = fld_adj;
      end
      SET_SEC: begin
        if (key_mode)
          state_nx = WRITE;
        else if (tmo_hit)
          state_nx = IDLE;
        else if (adj)
          edit_nx[7:0] = fld_adj;
      end
      WRITE: begin
        if (wr_ack)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      live_q   <= 24'h000000;
      edit_q   <= 24'h000000;
      wr_req_q <= 1'b0;
      wr_bcd_q <= 24'h000000;
    end else begin
      edit_q <= edit_nx;
      // The written time becomes the displayed time until the next live sample.
      if (state == IDLE && rtc_valid)
        live_q <= rtc_bcd;
      else if (state == WRITE && wr_ack)
        live_q <= wr_bcd_q;

      if (state == SET_SEC && key_mode) begin
        wr_req_q <= 1'b1;
        wr_bcd_q <= edit_q;
      end else if (state == WRITE && wr_ack) begin
        wr_req_q <= 1'b0;
      end
    end
  end

  assign seg_bcd = (state == IDLE) ? live_q : edit_q;
  assign wr_req  = wr_req_q;
  assign wr_bcd  = wr_bcd_q;

endmodule

`default_nettype wire

// File: tb/tb_rtc_time_set_ctrl.sv
// Scoreboard bench for rtc_time_set_ctrl: directed stimulus queues hand-computed expectations, a negedge monitor checks them.
`default_nettype none

module tb_rtc_time_set_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_mode = 1'b0;
  logic        key_up = 1'b0;
  logic        key_down = 1'b0;
  logic [23:0] rtc_bcd = 24'h000000;
  logic        rtc_valid = 1'b0;
  logic        wr_ack = 1'b0;
  logic [23:0] seg_bcd;
  logic [5:0]  seg_blink;
  logic        wr_req;
  logic [23:0] wr_bcd;

  always #5 clk = ~clk;

  rtc_time_set_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_mode  (key_mode),
    .key_up    (key_up),
    .key_down  (key_down),
    .rtc_bcd   (rtc_bcd),
    .rtc_valid (rtc_valid),
    .seg_bcd   (seg_bcd),
    .seg_blink (seg_blink),
    .wr_req    (wr_req),
    .wr_bcd    (wr_bcd),
    .wr_ack    (wr_ack)
  );

  typedef struct {
    int          cyc;
    string       tag;
    logic [23:0] seg;
    logic [5:0]  blink;
    logic        wreq;
    logic [23:0] wbcd;
    bit          md;
    bit          mw;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   done = 1'b0;
  bit   drained = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_chk++;
      if (e.cyc != cyc ||
          (e.md && (seg_bcd !== e.seg || seg_blink !== e.blink)) ||
          wr_req !== e.wreq ||
          (e.mw && wr_bcd !== e.wbcd)) begin
        n_fail++;
        $display("FAIL %s cyc=%0d: got seg=%h blink=%b wr_req=%b wr_bcd=%h, want seg=%h blink=%b wr_req=%b wr_bcd=%h",
                 e.tag, cyc, seg_bcd, seg_blink, wr_req, wr_bcd, e.seg, e.blink, e.wreq, e.wbcd);
      end
    end
    if (done && !drained) begin
      drained = 1'b1;
      n_chk++;
      if (sb.size() != 0) begin
        n_fail++;
        $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    key_mode  = 1'b0;
    key_up    = 1'b0;
    key_down  = 1'b0;
    rtc_valid = 1'b0;
    wr_ack    = 1'b0;
  endtask

  // Expectation for the outputs after the next rising edge.
  task automatic ex(input string tag, input logic [23:0] s, input logic [5:0] b,
                    input logic wq, input logic [23:0] wb, input bit md, input bit mw);
    exp_t x;
    x.cyc = cyc + 1; x.tag = tag; x.seg = s; x.blink = b;
    x.wreq = wq; x.wbcd = wb; x.md = md; x.mw = mw;
    sb.push_back(x);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ex("reset", 24'h0, 6'b0, 1'b0, 24'h0, 1'b1, 1'b1);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    tick();
    ex("reset_hold", 24'h0, 6'b0, 1'b0, 24'h0, 1'b1, 1'b1);
    tick();
    rtc_valid = 1'b1; rtc_bcd = 24'h999999; key_mode = 1'b1;
    ex("reset_ignores_inputs", 24'h0, 6'b0, 1'b0, 24'h0, 1'b1, 1'b1);
    tick();
    rst = 1'b0;

    // Live display updates
    rtc_valid = 1'b1; rtc_bcd = 24'h123456;
    ex("live_load", 24'h123456, 6'b0, 1'b0, 24'h0, 1'b1, 1'b0);
    tick();
    rtc_bcd = 24'h654321;
    ex("live_hold", 24'h123456, 6'b0, 1'b0, 24'h0, 1'b1, 1'b0);
    tick();
    rtc_valid = 1'b1; rtc_bcd = 24'h235959;
    ex("live_235959", 24'h235959, 6'b0, 1'b0, 24'h0, 1'b1, 1'b0);
    tick();

    // Field editing and wrap behaviour
    key_mode = 1'b1;
    ex("enter_hour", 24'h235959, 6'b000011, 1'b0, 24'h0, 1'b1, 1'b0);
    tick();
    key_up = 1'b1;
    ex("hour_up_wrap", 24'h005959, 6'b000011, 1'b0, 24'h0, 1'b1, 1'b0);
    tick();
    key_down = 1'b1;
    ex("hour_dn_wrap", 24'h235959, 6'b000011, 1'b0, 24'h0, 1'b1, 1'b0);
    tick();
    key_up = 1'b1; rtc_valid = 1'b1; rtc_bcd = 24'h111111;
    ex("hour_up_ignore_live", 24'h005959, 6'b000011, 1'b0, 24'h0, 1'b1, 1'b0);
    tick();
    key_mode = 1'b1; key_up = 1'b1;
    ex("mode_up_priority", 24'h005959, 6'b001100, 1'b0, 24'h0, 1'b1, 1'b0);
    tick();
    key_up = 1'b1;
    ex("min_up_wrap", 24'h000059, 6'b001100, 1'b0, 24'h0, 1'b1, 1'b0);
    tick();
    key_down = 1'b1;
    ex("min_dn_from_00", 24'h005959, 6'b001100, 1'b0, 24'h0, 1'b1, 1'b0);
    tick();
    key_up = 1'b1; key_down = 1'b1;
    ex("min_up_and_dn", 24'h005959, 6'b001100, 1'b0, 24'h0, 1'b1, 1'b0);
    tick();
    key_mode = 1'b1;
    ex("enter_sec", 24'h005959, 6'b110000, 1'b0, 24'h0, 1'b1, 1'b0);
    tick();
    key_up = 1'b1;
    ex("sec_up_wrap", 24'h005900, 6'b110000, 1'b0, 24'h0, 1'b1, 1'b0);
    tick();

    // Malformed minute nibble
    do_reset();
    rtc_valid = 1'b1; rtc_bcd = 24'h127A00;
    ex("live_bad", 24'h127A00, 6'b0, 1'b0, 24'h0, 1'b1, 1'b0);
    tick();
    key_mode = 1'b1;
    ex("bad_hour", 24'h127A00, 6'b000011, 1'b0, 24'h0, 1'b1, 1'b0);
    tick();
    key_mode = 1'b1;
    ex("bad_min", 24'h127A00, 6'b001100, 1'b0, 24'h0, 1'b1, 1'b0);
    tick();
    key_up = 1'b1;
    ex("bad_min_up", 24'h120000, 6'b001100, 1'b0, 24'h0, 1'b1, 1'b0);
    tick();

    // Full edit and write handshake
    do_reset();
    rtc_valid = 1'b1; rtc_bcd = 24'h071529;
    ex("wr_live", 24'h071529, 6'b0, 1'b0, 24'h0, 1'b1, 1'b0);
    tick();
    key_mode = 1'b1;
    ex("wr_hour", 24'h071529, 6'b000011, 1'b0, 24'h0, 1'b1, 1'b0);
    tick();
    key_up = 1'b1;
    ex("wr_hour_up", 24'h081529, 6'b000011, 1'b0, 24'h0, 1'b1, 1'b0);
    tick();
    key_mode = 1'b1; key_down = 1'b1;
    ex("wr_mode_dn_priority", 24'h081529, 6'b001100, 1'b0, 24'h0, 1'b1, 1'b0);
    tick();
    key_mode = 1'b1;
    ex("wr_sec", 24'h081529, 6'b110000, 1'b0, 24'h0, 1'b1, 1'b0);
    tick();
    key_up = 1'b1;
    ex("wr_sec_up", 24'h081530, 6'b110000, 1'b0, 24'h0, 1'b1, 1'b0);
    tick();
    key_mode = 1'b1;
    ex("write_enter", 24'h0, 6'b0, 1'b1, 24'h081530, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 20; i++) begin
      case (i % 3)
        0: key_mode = 1'b1;
        1: key_up = 1'b1;
        default: key_down = 1'b1;
      endcase
      if (i == 5) begin
        rtc_valid = 1'b1; rtc_bcd = 24'h999999;
      end
      ex("write_hold", 24'h0, 6'b0, 1'b1, 24'h081530, 1'b0, 1'b1);
      tick();
    end
    wr_ack = 1'b1;
    ex("write_ack", 24'h081530, 6'b0, 1'b0, 24'h0, 1'b1, 1'b0);
    tick();
    rtc_valid = 1'b1; rtc_bcd = 24'h111111;
    ex("live_resumes", 24'h111111, 6'b0, 1'b0, 24'h0, 1'b1, 1'b0);
    tick();
    wr_ack = 1'b1;
    ex("stray_ack", 24'h111111, 6'b0, 1'b0, 24'h0, 1'b1, 1'b0);
    tick();

    // Idle timeout in SET_HOUR
    rtc_valid = 1'b1; rtc_bcd = 24'h010203;
    ex("tmo_live", 24'h010203, 6'b0, 1'b0, 24'h0, 1'b1, 1'b0);
    tick();
    key_mode = 1'b1;
    ex("tmo_enter", 24'h010203, 6'b000011, 1'b0, 24'h0, 1'b1, 1'b0);
    tick();
    for (int k = 1; k <= 20; k++) begin
`ifdef RTC_SET_TIMEOUT_EN
      ex("tmo_wait", 24'h010203, (k >= 16) ? 6'b000000 : 6'b000011, 1'b0, 24'h0, 1'b1, 1'b0);
`else
      ex("tmo_wait", 24'h010203, 6'b000011, 1'b0, 24'h0, 1'b1, 1'b0);
`endif
      tick();
    end
    rtc_valid = 1'b1; rtc_bcd = 24'h222222;
`ifdef RTC_SET_TIMEOUT_EN
    ex("tmo_live_restore", 24'h222222, 6'b0, 1'b0, 24'h0, 1'b1, 1'b0);
`else
    ex("tmo_stays_set", 24'h010203, 6'b000011, 1'b0, 24'h0, 1'b1, 1'b0);
`endif
    tick();

    // Reset during an outstanding write
    do_reset();
    rtc_valid = 1'b1; rtc_bcd = 24'h101010;
    ex("rw_live", 24'h101010, 6'b0, 1'b0, 24'h0, 1'b1, 1'b0);
    tick();
    for (int m = 0; m < 3; m++) begin
      key_mode = 1'b1;
      ex("rw_step", 24'h101010, (m == 0) ? 6'b000011 : (m == 1) ? 6'b001100 : 6'b110000,
         1'b0, 24'h0, 1'b1, 1'b0);
      tick();
    end
    key_mode = 1'b1;
    ex("rw_write", 24'h0, 6'b0, 1'b1, 24'h101010, 1'b0, 1'b1);
    tick();
    rst = 1'b1;
    ex("rw_reset", 24'h0, 6'b0, 1'b0, 24'h0, 1'b1, 1'b1);
    tick();
    rst = 1'b0;
    wr_ack = 1'b1;
    ex("rw_late_ack", 24'h0, 6'b0, 1'b0, 24'h0, 1'b1, 1'b1);
    tick();
    for (int n = 0; n < 3; n++) begin
      ex("rw_quiet", 24'h0, 6'b0, 1'b0, 24'h0, 1'b1, 1'b1);
      tick();
    end

    tick();
    done = 1'b1;
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rtc_time_set_ctrl.md
RTC_TIME_SET_CTRL -- requirements
Module: rtc_time_set_ctrl

Interface
- REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 500000000 (10 s at 50 MHz), meaning idle cycles in any SET state before an abort without write.
- REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
- REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
- REQ-004 SHALL have port key_mode  input  1  debounced single-cycle pulse that advances the edit field.
- REQ-005 SHALL have port key_up  input  1  debounced single-cycle pulse that increments the selected field.
- REQ-006 SHALL have port key_down  input  1  debounced single-cycle pulse that decrements the selected field.
- REQ-007 SHALL have port rtc_bcd  input  24  live time from the RTC reader, {HH,MM,SS} as packed BCD.
- REQ-008 SHALL have port rtc_valid  input  1  rtc_bcd qualifier, one-cycle strobe.
- REQ-009 SHALL have port seg_bcd  output  24  value to the display driver; [23:20] is digit 0.
- REQ-010 SHALL have port seg_blink  output  6  per-digit blink enable; bit n blinks digit n.
- REQ-011 SHALL have port wr_req  output  1  request to write the time to the RTC.
- REQ-012 SHALL have port wr_bcd  output  24  time to write, {HH,MM,SS} BCD; stable while wr_req=1.
- REQ-013 SHALL have port wr_ack  input  1  RTC writer acceptance, one-cycle strobe.

Function
- REQ-014 SHALL implement states IDLE, SET_HOUR, SET_MIN, SET_SEC, WRITE.
- REQ-015 In IDLE, seg_bcd SHALL load rtc_bcd on the cycle after rtc_valid=1 and hold otherwise; seg_blink=6'b000000.
- REQ-016 key_mode SHALL cause these transitions: IDLE->SET_HOUR, which copies seg_bcd into the edit register; SET_HOUR->SET_MIN; SET_MIN->SET_SEC; SET_SEC->WRITE.
- REQ-017 In SET states, seg_bcd SHALL show the edit register and SHALL ignore rtc_valid.
- REQ-018 seg_blink SHALL be 6'b000011 in SET_HOUR, 6'b001100 in SET_MIN and 6'b110000 in SET_SEC.
- REQ-019 key_up SHALL increment the selected field in BCD; the result is visible on seg_bcd one cycle later.
- REQ-020 Field maxima SHALL be 23 for hour and 59 for minute and second.
- REQ-021 Incrementing a field whose value is at or above its maximum, or holds an invalid BCD nibble, SHALL yield 00.
- REQ-022 key_down SHALL decrement the selected field in BCD; decrementing 00, or a field above its maximum or with an invalid nibble, SHALL yield the maximum.
- REQ-023 key_up and key_down asserted in the same cycle SHALL leave the field unchanged.
- REQ-024 key_mode asserted together with up or down SHALL take the transition only, with no adjustment.
- REQ-025 On entering WRITE, wr_bcd SHALL equal the edit register and wr_req=1; wr_req and wr_bcd SHALL hold until wr_ack=1 is sampled.
- REQ-026 On the cycle after wr_ack is sampled, wr_req=0, state=IDLE and seg_bcd=wr_bcd, then live updates resume.
- REQ-027 In WRITE, all keys SHALL be ignored, and wr_ack seen outside WRITE SHALL be ignored.

Reset
- REQ-028 While rst=1, the block SHALL hold: state=IDLE, seg_bcd=24'h000000, seg_blink=0, wr_req=0, wr_bcd=0, edit register=0, timeout counter=0.
- REQ-029 rst in any state, including WRITE with wr_req=1, SHALL abort the operation with no write issued afterwards.

Configuration
- REQ-030 With RTC_SET_TIMEOUT_EN defined, a counter SHALL clear on any key pulse and on entry to a SET state, and count every cycle in SET states.
- REQ-031 With RTC_SET_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES-1 SHALL send the block to IDLE with no write, seg_blink=0 and the next rtc_valid restoring live time.
- REQ-032 Without RTC_SET_TIMEOUT_EN, the counter SHALL be absent, SET states SHALL persist indefinitely and TIMEOUT_CYCLES SHALL be unused.

Verification
- REQ-033 rtc_valid with rtc_bcd=24'h123456 in IDLE -> seg_bcd=24'h123456 next cycle, seg_blink=0.
- REQ-034 Live value 23:59:59; mode, then up -> hour 00, seg_bcd=24'h005959, seg_blink=6'b000011.
- REQ-035 SET_MIN with minute 00 and down -> 59; up and down in the same cycle -> unchanged; minute 0x7A with up -> 00.
- REQ-036 Edit to 24'h081530, mode to WRITE, wr_ack held low 20 cycles then pulsed -> wr_req high and wr_bcd=24'h081530 throughout, wr_req=0 and IDLE the cycle after the ack, keys ignored meanwhile.
- REQ-037 TIMEOUT_CYCLES=16 with the macro defined, enter SET_HOUR, no keys -> IDLE after 16 cycles, wr_req never asserted; same stimulus without the macro -> stays in SET_HOUR.
- REQ-038 rst pulsed while wr_req=1 -> all outputs at reset values next cycle, and a later wr_ack has no effect.
